// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch memory: FSM state encoding,
// default configuration constants and the fetch address check.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } imem_state_e;

    localparam int unsigned IMEM_DATA_W      = 32;
    localparam int unsigned IMEM_DEPTH       = 128;
    localparam int unsigned IMEM_WAIT_STATES = 0;

    // A fetch is bad when it is not word aligned or lies beyond the array.
    function automatic logic imem_addr_err(input logic [31:0] addr, input int unsigned addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// No reset, so contents survive a reset of the surrounding logic.
module imem_array
    import imem_pkg::*;
#(
    parameter  int unsigned DATA_W = IMEM_DATA_W,
    parameter  int unsigned DEPTH  = IMEM_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Word write on the rising edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory with a single-outstanding request/response port,
// configurable read wait states and a program-load write port.
// Optional feature: define IMEM_BOOTROM_EN to add an INIT state that fills
// memory[i] = i*4 after every reset before requests are accepted.
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter  int unsigned DATA_W      = IMEM_DATA_W,
    parameter  int unsigned DEPTH       = IMEM_DEPTH,
    parameter  int unsigned WAIT_STATES = IMEM_WAIT_STATES,
    localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req_Valid,
    input  logic [31:0]       Req_Addr,
    output logic              Req_Ready,
    output logic              Resp_Valid,
    input  logic              Resp_Ready,
    output logic [DATA_W-1:0] Resp_Instr,
    output logic              Resp_Err,
    input  logic              Ld_En,
    input  logic [ADDR_W-1:0] Ld_Addr,
    input  logic [DATA_W-1:0] Ld_Data,
    output logic              Busy
);

    localparam logic [2:0] WS_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

`ifdef IMEM_BOOTROM_EN
    localparam imem_state_e RESET_STATE = ST_INIT;
`else
    localparam imem_state_e RESET_STATE = ST_IDLE;
`endif

    imem_state_e       state_q, state_d;
    logic [2:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] instr_q, instr_d;

`ifdef IMEM_BOOTROM_EN
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
`endif

    logic [ADDR_W-1:0] req_idx;
    logic              req_err;
    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    assign req_idx = Req_Addr[ADDR_W+1:2];
    assign req_err = imem_addr_err(Req_Addr, ADDR_W);

    // Loads win over fetches in IDLE; Rst_n gating keeps Ready low while in reset.
    assign Req_Ready  = Rst_n && (state_q == ST_IDLE) && !Ld_En;
    assign accept     = Req_Valid && Req_Ready;
    assign Resp_Valid = (state_q == ST_RESP);
    assign Resp_Instr = instr_q;
    assign Resp_Err   = err_q;
    assign Busy       = (state_q != ST_IDLE);

    // With zero wait states RESP is entered on the accept edge, so the read
    // must come straight from the request address in IDLE.
    assign mem_raddr = (state_q == ST_IDLE) ? req_idx : idx_q;

    // Write port: boot fill during INIT, program loads otherwise.
    always_comb begin
        mem_we    = Ld_En && (state_q != ST_INIT);
        mem_waddr = Ld_Addr;
        mem_wdata = Ld_Data;
`ifdef IMEM_BOOTROM_EN
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt_q;
            mem_wdata = DATA_W'({init_cnt_q, 2'b00});
        end
`endif
    end

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (Clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    // Next-state logic; the response word is captured only on RESP entry.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        instr_d = instr_q;
`ifdef IMEM_BOOTROM_EN
        init_cnt_d = init_cnt_q;
`endif
        case (state_q)
            ST_INIT: begin
`ifdef IMEM_BOOTROM_EN
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (accept) begin
                    idx_d = req_idx;
                    err_d = req_err;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WS_LOAD;
                    end else begin
                        state_d = ST_RESP;
                        instr_d = req_err ? '0 : mem_rdata;
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 3'd0) begin
                    state_d = ST_RESP;
                    instr_d = err_q ? '0 : mem_rdata;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (Resp_Ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // State and response registers; reset drops any outstanding request.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= RESET_STATE;
            wcnt_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            instr_q <= '0;
`ifdef IMEM_BOOTROM_EN
            init_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            instr_q <= instr_d;
`ifdef IMEM_BOOTROM_EN
            init_cnt_q <= init_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: two instances (0 and 3 wait
// states), table-driven load/fetch vectors with a response scoreboard, and
// hand-written sequences for back-pressure, load/request collision and
// reset mid-transaction. Honours IMEM_BOOTROM_EN when defined.
module tb_instr_fetch_mem;

    localparam int DW  = 32;
    localparam int DEP = 128;
    localparam int AW  = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid  [2];
    logic [31:0]   req_addr   [2];
    logic          req_ready  [2];
    logic          resp_valid [2];
    logic          resp_ready [2];
    logic [DW-1:0] resp_instr [2];
    logic          resp_err   [2];
    logic          ld_en      [2];
    logic [AW-1:0] ld_addr    [2];
    logic [DW-1:0] ld_data    [2];
    logic          busy       [2];

    instr_fetch_mem #(.DATA_W(DW), .DEPTH(DEP), .WAIT_STATES(0)) u_dut0 (
        .Clk(clk), .Rst_n(rst_n),
        .Req_Valid(req_valid[0]), .Req_Addr(req_addr[0]), .Req_Ready(req_ready[0]),
        .Resp_Valid(resp_valid[0]), .Resp_Ready(resp_ready[0]),
        .Resp_Instr(resp_instr[0]), .Resp_Err(resp_err[0]),
        .Ld_En(ld_en[0]), .Ld_Addr(ld_addr[0]), .Ld_Data(ld_data[0]),
        .Busy(busy[0])
    );

    instr_fetch_mem #(.DATA_W(DW), .DEPTH(DEP), .WAIT_STATES(3)) u_dut3 (
        .Clk(clk), .Rst_n(rst_n),
        .Req_Valid(req_valid[1]), .Req_Addr(req_addr[1]), .Req_Ready(req_ready[1]),
        .Resp_Valid(resp_valid[1]), .Resp_Ready(resp_ready[1]),
        .Resp_Instr(resp_instr[1]), .Resp_Err(resp_err[1]),
        .Ld_En(ld_en[1]), .Ld_Addr(ld_addr[1]), .Ld_Data(ld_data[1]),
        .Busy(busy[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [AW-1:0] li;
        logic [31:0]   ld;
        logic [31:0]   addr;
        logic [31:0]   ei;
        logic          ee;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[8];
    logic [31:0] mem_m[2][DEP];
    int          checks = 0;
    int          errors = 0;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic load(input int d, input logic [AW-1:0] idx, input logic [31:0] data);
        @(negedge clk);
        ld_en[d] = 1'b1; ld_addr[d] = idx; ld_data[d] = data;
        mem_m[d][idx] = data;
        @(negedge clk);
        ld_en[d] = 1'b0;
    endtask

    task automatic wait_resp(input int d, input string tag);
        exp_t e;
        int   n;
        n = 1;
        #1;
        while (resp_valid[d] !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        e = sb.pop_front();
        chk({tag, " latency"}, n, e.lat);
        chk({tag, " instr"}, resp_instr[d], e.instr);
        chk({tag, " err"}, resp_err[d], e.err);
        chk({tag, " ready_in_resp"}, req_ready[d], 0);
        resp_ready[d] = 1'b1;
        req_valid[d]  = 1'b1;
        #1 chk({tag, " ready_on_exit"}, req_ready[d], 0);
        @(negedge clk);
        resp_ready[d] = 1'b0;
        req_valid[d]  = 1'b0;
        #1 chk({tag, " valid_dropped"}, resp_valid[d], 0);
    endtask

    task automatic fetch(input int d, input logic [31:0] addr, input logic [31:0] ei,
                         input logic ee, input string tag);
        exp_t e;
        @(negedge clk);
        ld_en[d] = 1'b0; req_valid[d] = 1'b1; req_addr[d] = addr;
        #1 chk({tag, " accept_ready"}, req_ready[d], 1);
        e.instr = ei; e.err = ee; e.lat = ws_of(d) + 1;
        sb.push_back(e);
        @(negedge clk);
        req_valid[d] = 1'b0;
        wait_resp(d, tag);
    endtask

    task automatic model_fetch(input int d, input logic [31:0] addr, input string tag);
        logic e;
        e = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
        fetch(d, addr, e ? 32'h0 : mem_m[d][addr[AW+1:2]], e, tag);
    endtask

    task automatic post_reset();
`ifdef IMEM_BOOTROM_EN
        int n;
        n = 0;
        #1;
        while ((busy[0] !== 1'b0 || busy[1] !== 1'b0) && n < 300) begin
            @(negedge clk); #1; n++;
        end
        chk("init_cycles", n, DEP);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEP; i++) mem_m[d][i] = i * 4;
            chk($sformatf("post_init_ready d%0d", d), req_ready[d], 1);
        end
`else
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("post_rst_ready d%0d", d), req_ready[d], 1);
            chk($sformatf("post_rst_busy d%0d", d), busy[d], 0);
        end
`endif
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s rst_ready d%0d", tag, d), req_ready[d], 0);
            chk($sformatf("%s rst_valid d%0d", tag, d), resp_valid[d], 0);
            chk($sformatf("%s rst_instr d%0d", tag, d), resp_instr[d], 0);
            chk($sformatf("%s rst_err d%0d", tag, d), resp_err[d], 0);
`ifdef IMEM_BOOTROM_EN
            chk($sformatf("%s rst_busy d%0d", tag, d), busy[d], 1);
`else
            chk($sformatf("%s rst_busy d%0d", tag, d), busy[d], 0);
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
        post_reset();
    endtask

    initial begin
        int n;
        int rises;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_addr[d] = '0; resp_ready[d] = 1'b0;
            ld_en[d] = 1'b0; ld_addr[d] = '0; ld_data[d] = '0;
        end

        tbl[0] = '{li: 7'd5,   ld: 32'h2010000E, addr: 32'h00000014, ei: 32'h2010000E, ee: 1'b0};
        tbl[1] = '{li: 7'd0,   ld: 32'hDEADBEEF, addr: 32'h00000000, ei: 32'hDEADBEEF, ee: 1'b0};
        tbl[2] = '{li: 7'd127, ld: 32'hA5A5A5A5, addr: 32'h000001FC, ei: 32'hA5A5A5A5, ee: 1'b0};
        tbl[3] = '{li: 7'd9,   ld: 32'h0F0F0F0F, addr: 32'h00000024, ei: 32'h0F0F0F0F, ee: 1'b0};
        tbl[4] = '{li: 7'd1,   ld: 32'h11111111, addr: 32'h00000006, ei: 32'h00000000, ee: 1'b1};
        tbl[5] = '{li: 7'd0,   ld: 32'h22222222, addr: 32'h00000200, ei: 32'h00000000, ee: 1'b1};
        tbl[6] = '{li: 7'd3,   ld: 32'h33333333, addr: 32'h8000000C, ei: 32'h00000000, ee: 1'b1};
        tbl[7] = '{li: 7'd2,   ld: 32'h44444444, addr: 32'h00000009, ei: 32'h00000000, ee: 1'b1};

        do_reset("por");

`ifdef IMEM_BOOTROM_EN
        for (int d = 0; d < 2; d++) begin
            fetch(d, 32'h0000001C, 32'h0000001C, 1'b0, $sformatf("boot d%0d", d));
        end
`endif

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                load(d, tbl[i].li, tbl[i].ld);
                fetch(d, tbl[i].addr, tbl[i].ei, tbl[i].ee, $sformatf("vec%0d d%0d", i, d));
            end
        end

        // Back-pressure: response held for 5 cycles while the same index is rewritten.
        load(1, 7'd7, 32'h77770007);
        @(negedge clk);
        req_valid[1] = 1'b1; req_addr[1] = 32'h0000001C;
        @(negedge clk);
        req_valid[1] = 1'b0;
        n = 1;
        #1;
        while (resp_valid[1] !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("hold latency", n, 4);
        for (int c = 0; c < 5; c++) begin
            ld_en[1] = (c == 2); ld_addr[1] = 7'd7; ld_data[1] = 32'h99990009;
            if (c == 2) mem_m[1][7] = 32'h99990009;
            chk($sformatf("hold valid c%0d", c), resp_valid[1], 1);
            chk($sformatf("hold instr c%0d", c), resp_instr[1], 32'h77770007);
            chk($sformatf("hold ready c%0d", c), req_ready[1], 0);
            @(negedge clk); #1;
        end
        ld_en[1] = 1'b0;
        resp_ready[1] = 1'b1;
        @(negedge clk);
        resp_ready[1] = 1'b0;
        #1 chk("hold released", resp_valid[1], 0);
        model_fetch(1, 32'h0000001C, "hold reload");

        // Load and request in the same IDLE cycle: load first, request next cycle.
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            ld_en[d] = 1'b1; ld_addr[d] = 7'd10; ld_data[d] = 32'hC0DE0000 + d;
            mem_m[d][10] = 32'hC0DE0000 + d;
            req_valid[d] = 1'b1; req_addr[d] = 32'h00000028;
            #1 chk($sformatf("collide ready d%0d", d), req_ready[d], 0);
            model_fetch(d, 32'h00000028, $sformatf("collide d%0d", d));
        end

        // Reset while the 3-wait-state instance is in WAIT: response must never appear.
        @(negedge clk);
        req_valid[1] = 1'b1; req_addr[1] = 32'h00000014;
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1 chk("midwait busy", busy[1], 1);
        do_reset("midwait");
        rises = 0;
        for (int c = 0; c < 10; c++) begin
            if (resp_valid[1] === 1'b1) rises++;
            @(negedge clk); #1;
        end
        chk("midwait no_resp", rises, 0);

        // Contents survive reset (or are re-filled under the boot ROM option).
        model_fetch(1, 32'h00000014, "retain d1");
        model_fetch(0, 32'h000001FC, "retain d0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the instruction word width in bits.
REQ-002 Parameter DEPTH, default 128, SHALL set the word count, power of two, 16 to 4096; ADDR_W = log2(DEPTH).
REQ-003 Parameter WAIT_STATES, default 0, SHALL set extra read-latency cycles, 0 to 7.
REQ-004 Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 Rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 Req_Valid  input  1  SHALL indicate a fetch request.
REQ-007 Req_Addr  input  32  SHALL be the byte address of the fetch.
REQ-008 Req_Ready  output  1  SHALL indicate that a request is accepted this cycle.
REQ-009 Resp_Valid  output  1  SHALL indicate that Resp_Instr and Resp_Err are valid.
REQ-010 Resp_Ready  input  1  SHALL indicate that the consumer takes the response.
REQ-011 Resp_Instr  output  DATA_W  SHALL carry the fetched instruction.
REQ-012 Resp_Err  output  1  SHALL flag a misaligned or out-of-range fetch.
REQ-013 Ld_En  input  1  SHALL request a program-load write.
REQ-014 Ld_Addr  input  ADDR_W  SHALL be the word index for the load.
REQ-015 Ld_Data  input  DATA_W  SHALL be the word to write.
REQ-016 Busy  output  1  SHALL be high while the block is in any state other than IDLE.

Function
REQ-017 The FSM SHALL have four states, INIT, IDLE, WAIT and RESP.
REQ-018 Req_Ready SHALL be high only in IDLE with Ld_En low; a request is accepted when Req_Valid and Req_Ready are both high.
REQ-019 On accept, the FSM SHALL capture the word index Req_Addr[ADDR_W+1:2] and the error condition, then go to WAIT if WAIT_STATES>0, otherwise to RESP.
REQ-020 In WAIT, a down-counter loaded with WAIT_STATES-1 SHALL decrement each cycle; at zero the FSM SHALL go to RESP.
REQ-021 Response latency SHALL be WAIT_STATES+1 cycles from the accept edge to Resp_Valid high.
REQ-022 In RESP, Resp_Valid SHALL be high and Resp_Instr/Resp_Err SHALL be held stable until Resp_Ready is sampled high, then the FSM SHALL return to IDLE.
REQ-023 No new request SHALL be accepted in the RESP-exit cycle; at most one request SHALL be outstanding.
REQ-024 Resp_Err SHALL be 1 when Req_Addr[1:0]!=0 or Req_Addr[31:ADDR_W+2]!=0; Resp_Instr SHALL then be all zeros.
REQ-025 Ld_En SHALL write Ld_Data to memory[Ld_Addr] on the clock edge in IDLE, WAIT or RESP; it is ignored in INIT.
REQ-026 Ld_En high in IDLE SHALL block request acceptance that cycle, so loads have priority.
REQ-027 The read value SHALL be sampled at the RESP entry edge; a load to the same index in an earlier cycle SHALL be visible (write-before-read).
REQ-028 A load during WAIT/RESP to the in-flight index SHALL NOT alter an already-captured Resp_Instr.

Reset
REQ-029 On Rst_n low: Req_Ready=0, Resp_Valid=0, Resp_Instr=0, Resp_Err=0, wait counter=0; the state SHALL be INIT if IMEM_BOOTROM_EN is defined, otherwise IDLE.
REQ-030 A reset mid-transaction SHALL drop the outstanding request without a response.
REQ-031 Memory contents SHALL be retained across reset unless re-initialised under IMEM_BOOTROM_EN.

Configuration
REQ-032 With IMEM_BOOTROM_EN defined, INIT SHALL write memory[i]=i*4 (truncated to DATA_W) for i=0..DEPTH-1, one word per cycle, then enter IDLE after DEPTH cycles, with Busy=1 throughout.
REQ-033 Without IMEM_BOOTROM_EN, INIT SHALL not exist, contents are undefined until loaded, and Req_Ready SHALL be high in the first cycle after reset release.

Structure
REQ-034 A shared package imem_pkg SHALL hold the FSM state enum and the default constants for DATA_W, DEPTH and WAIT_STATES.
REQ-035 The storage array SHALL be a sub-module imem_array, with one synchronous write port and an asynchronous read.

Verification
REQ-036 IMEM_BOOTROM_EN defined, reset release, wait for Busy=0, fetch 0x0000001C -> Resp_Instr=0x0000001C, Resp_Err=0, 1 cycle after accept.
REQ-037 WAIT_STATES=3, load index 5 with 0x2010000E, fetch 0x14 -> Resp_Valid exactly 4 cycles after accept, Resp_Instr=0x2010000E.
REQ-038 Fetch 0x00000006 -> Resp_Err=1, Resp_Instr=0; fetch 0x00000200 with DEPTH=128 -> Resp_Err=1.
REQ-039 Hold Resp_Ready=0 for 5 cycles and pulse Ld_En to the same index -> Resp_Instr stable, Req_Ready=0 throughout.
REQ-040 Req_Valid and Ld_En high together in IDLE -> load written, Req_Ready=0, request accepted next cycle; reset asserted during WAIT -> Resp_Valid never rises.
